// File: rtl/tc7_pkg.sv
// Shared types and helpers for the thermometer-coded modulo-7 datapath.
// Optional checker build: TC7_CHECK_EN.
package tc7_pkg;

    localparam int TC7_W   = 6;
    localparam int TC7_MOD = 7;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } tc7_state_e;

    // Legal codewords are a run of ones starting at bit 0, so x & (x+1) must be zero.
    function automatic logic tc7_is_legal(input logic [TC7_W-1:0] x);
        logic [TC7_W:0] inc;
        inc = {1'b0, x} + 7'd1;
        return ((inc[TC7_W-1:0] & x) == '0);
    endfunction

    function automatic int tc7_value(input logic [TC7_W-1:0] x);
        int n;
        n = 0;
        for (int k = 0; k < TC7_W; k++) begin
            if (x[k]) n++;
        end
        return n;
    endfunction

    function automatic logic [TC7_W-1:0] tc7_encode(input int v);
        logic [TC7_W-1:0] r;
        r = '0;
        for (int k = 0; k < TC7_W; k++) begin
            r[k] = (k < v);
        end
        return r;
    endfunction

endpackage

// File: rtl/tc7_add.sv
// Combinational thermometer-coded modulo-7 adder.
// Latency: zero cycles; no flow control.
module tc7_add
    import tc7_pkg::*;
(
    input  logic [TC7_W-1:0] a_i,
    input  logic [TC7_W-1:0] b_i,
    output logic [TC7_W-1:0] sum_o
);

    always_comb begin
        int s;
        s = tc7_value(a_i) + tc7_value(b_i);
        if (s >= TC7_MOD) s = s - TC7_MOD;
        sum_o = tc7_encode(s);
    end

endmodule

// File: rtl/tc7_adder_arbiter_rr.sv
// Round-robin arbiter: one-hot grant and binary index, pointer moves past the winner.
// Latency: grant is combinational; backpressure via can_accept_i gating every grant.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int ID_W = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req_i,
    input  logic            advance_i,
    input  logic            can_accept_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [ID_W-1:0] gnt_idx_o
);

    logic [ID_W-1:0] ptr_q, ptr_d;
    logic            found;

    // Two passes: requesters at or above the pointer first, then wrap to the lowest.
    always_comb begin
        found     = 1'b0;
        gnt_idx_o = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!found && req_i[i] && (ID_W'(i) >= ptr_q)) begin
                found     = 1'b1;
                gnt_idx_o = ID_W'(i);
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!found && req_i[i]) begin
                found     = 1'b1;
                gnt_idx_o = ID_W'(i);
            end
        end
        gnt_o = '0;
        for (int i = 0; i < NREQ; i++) begin
            gnt_o[i] = found && can_accept_i && (gnt_idx_o == ID_W'(i));
        end
        ptr_d = ptr_q;
        if (advance_i) begin
            ptr_d = (gnt_idx_o == ID_W'(NREQ - 1)) ? '0 : gnt_idx_o + ID_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) ptr_q <= '0;
        else        ptr_q <= ptr_d;
    end

endmodule

// File: rtl/tc7_adder_arbiter.sv
// Shares one TC mod-7 adder among NREQ requesters; result held in a one-entry register.
// Latency 1 cycle; refills in the drain cycle; grants stall while full and rsp_ready is low.
// Optional build macro TC7_CHECK_EN adds rsp_err for non-thermometer operands.
module tc7_adder_arbiter
    import tc7_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int ID_W = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*TC7_W-1:0] req_a,
    input  logic [NREQ*TC7_W-1:0] req_b,
    output logic [NREQ-1:0]       req_ready,
    output logic                  rsp_valid,
    output logic [TC7_W-1:0]      rsp_sum,
    output logic [ID_W-1:0]       rsp_id,
    input  logic                  rsp_ready,
    output logic                  busy
`ifdef TC7_CHECK_EN
    ,
    output logic                  rsp_err
`endif
);

    tc7_state_e       state_q;
    logic             rsp_valid_q;
    logic [TC7_W-1:0] rsp_sum_q, rsp_sum_d;
    logic [ID_W-1:0]  rsp_id_q, gnt_idx;
    logic [NREQ-1:0]  gnt;
    logic [TC7_W-1:0] a_sel, b_sel;
    logic             can_accept, xfer;

    assign can_accept = rst_n && ((state_q == EMPTY) || rsp_ready);
    assign xfer       = |gnt;

    rr_arbiter #(.NREQ(NREQ), .ID_W(ID_W)) u_arb (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_i        (req_valid),
        .advance_i    (xfer),
        .can_accept_i (can_accept),
        .gnt_o        (gnt),
        .gnt_idx_o    (gnt_idx)
    );

    // Operands are selected by the grant index only; the grant never depends on them.
    always_comb begin
        a_sel = '0;
        b_sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_idx == ID_W'(i)) begin
                a_sel = req_a[i*TC7_W +: TC7_W];
                b_sel = req_b[i*TC7_W +: TC7_W];
            end
        end
    end

    tc7_add u_add (
        .a_i   (a_sel),
        .b_i   (b_sel),
        .sum_o (rsp_sum_d)
    );

`ifdef TC7_CHECK_EN
    logic rsp_err_q, rsp_err_d;
    assign rsp_err_d = !tc7_is_legal(a_sel) || !tc7_is_legal(b_sel);
    assign rsp_err   = rsp_err_q;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= EMPTY;
            rsp_valid_q <= 1'b0;
            rsp_sum_q   <= '0;
            rsp_id_q    <= '0;
`ifdef TC7_CHECK_EN
            rsp_err_q   <= 1'b0;
`endif
        end else if (xfer) begin
            state_q     <= FULL;
            rsp_valid_q <= 1'b1;
            rsp_sum_q   <= rsp_sum_d;
            rsp_id_q    <= gnt_idx;
`ifdef TC7_CHECK_EN
            rsp_err_q   <= rsp_err_d;
`endif
        end else if ((state_q == FULL) && rsp_ready) begin
            state_q     <= EMPTY;
            rsp_valid_q <= 1'b0;
        end
    end

    assign req_ready = gnt;
    assign rsp_valid = rsp_valid_q;
    assign rsp_sum   = rsp_sum_q;
    assign rsp_id    = rsp_id_q;
    assign busy      = rsp_valid_q || (|req_valid);

endmodule

// File: tb/tb_tc7_adder_arbiter.sv
// Directed bench for tc7_adder_arbiter; also covers rsp_err when built with TC7_CHECK_EN.
module tb_tc7_adder_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [23:0] req_a, req_b;
    logic [3:0]  req_ready;
    logic        rsp_valid;
    logic [5:0]  rsp_sum;
    logic [1:0]  rsp_id;
    logic        rsp_ready;
    logic        busy;
`ifdef TC7_CHECK_EN
    logic        rsp_err;
`endif

    int n_total  = 0;
    int n_passed = 0;

    tc7_adder_arbiter #(.NREQ(4), .ID_W(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_sum   (rsp_sum),
        .rsp_id    (rsp_id),
        .rsp_ready (rsp_ready),
        .busy      (busy)
`ifdef TC7_CHECK_EN
        ,
        .rsp_err   (rsp_err)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [5:0] enc(input int v);
        logic [6:0] t;
        t = (7'd1 << v) - 7'd1;
        return t[5:0];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [5:0] a, input logic [5:0] b);
        req_a[6*i +: 6] = a;
        req_b[6*i +: 6] = b;
    endtask

    task automatic op0(input string tag, input int va, input int vb, input logic [5:0] exp);
        set_op(0, enc(va), enc(vb));
        req_valid = 4'b0001;
        tick();
        chk(tag, {26'd0, rsp_sum}, {26'd0, exp});
        req_valid = 4'b0000;
    endtask

    logic [5:0] held_sum;
    int         exp_id;

    initial begin
        rst_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
        tick();
        req_valid = 4'hF;
        #1;
        chk("rst_req_ready", {28'd0, req_ready}, 32'd0);
        tick();
        req_valid = '0;
        rst_n = 1'b1;
        #1;
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_sum", {26'd0, rsp_sum}, 32'd0);
        chk("rst_rsp_id", {30'd0, rsp_id}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);

        // Single requester 1: 3 + 5 = 8 mod 7 = 1
        set_op(1, 6'b000111, 6'b011111);
        req_valid = 4'b0010; rsp_ready = 1'b1;
        #1;
        chk("single_ready", {28'd0, req_ready}, 32'b0010);
        chk("single_busy", {31'd0, busy}, 32'd1);
        tick();
        chk("single_valid", {31'd0, rsp_valid}, 32'd1);
        chk("single_sum", {26'd0, rsp_sum}, 32'b000001);
        chk("single_id", {30'd0, rsp_id}, 32'd1);
        req_valid = '0;

        op0("sum_0_0", 0, 0, 6'b000000);
        chk("sum_0_0_id", {30'd0, rsp_id}, 32'd0);
        op0("sum_6_6", 6, 6, 6'b011111);
        op0("sum_3_4", 3, 4, 6'b000000);
        op0("sum_6_0", 6, 0, 6'b111111);
        for (int x = 0; x < 7; x++) begin
            for (int y = 0; y < 7; y++) begin
                op0($sformatf("sweep_%0d_%0d", x, y), x, y, enc((x + y) % 7));
            end
        end
        chk("sweep_valid", {31'd0, rsp_valid}, 32'd1);
        tick();
        chk("drain_valid", {31'd0, rsp_valid}, 32'd0);

        // Reset while full and stalled
        rsp_ready = 1'b0;
        set_op(2, enc(3), enc(3));
        req_valid = 4'b0100;
        tick();
        chk("mid_load_valid", {31'd0, rsp_valid}, 32'd1);
        chk("mid_load_sum", {26'd0, rsp_sum}, 32'b111111);
        chk("mid_load_id", {30'd0, rsp_id}, 32'd2);
        req_valid = '0;
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        chk("mid_rst_valid", {31'd0, rsp_valid}, 32'd0);
        chk("mid_rst_sum", {26'd0, rsp_sum}, 32'd0);
        chk("mid_rst_id", {30'd0, rsp_id}, 32'd0);
        req_valid = 4'hF;
        #1;
        chk("mid_rst_ptr", {28'd0, req_ready}, 32'b0001);
        req_valid = '0; rsp_ready = 1'b1;
        tick();
        tick();
        chk("mid_rst_no_stale", {31'd0, rsp_valid}, 32'd0);

        // All four requesters valid continuously
        for (int i = 0; i < 4; i++) set_op(i, enc(i), enc(i + 2));
        req_valid = 4'hF;
        exp_id = 0;
        for (int c = 0; c < 8; c++) begin
            #1;
            chk($sformatf("rr_onehot_%0d", c), {31'd0, $onehot(req_ready)}, 32'd1);
            chk($sformatf("rr_ready_%0d", c), {28'd0, req_ready}, 32'd1 << exp_id);
            tick();
            chk($sformatf("rr_valid_%0d", c), {31'd0, rsp_valid}, 32'd1);
            chk($sformatf("rr_id_%0d", c), {30'd0, rsp_id}, exp_id);
            chk($sformatf("rr_sum_%0d", c), {26'd0, rsp_sum}, {26'd0, enc((2 * exp_id + 2) % 7)});
            exp_id = (exp_id + 1) % 4;
        end
        req_valid = '0;
        tick();

        // Backpressure with requesters 1 and 3 waiting
        rsp_ready = 1'b0;
        set_op(1, enc(4), enc(1));
        set_op(3, enc(6), enc(2));
        req_valid = 4'b1010;
        #1;
        chk("bp_first_ready", {28'd0, req_ready}, 32'b0010);
        tick();
        chk("bp_first_id", {30'd0, rsp_id}, 32'd1);
        held_sum = rsp_sum;
        chk("bp_first_sum", {26'd0, held_sum}, {26'd0, enc(5)});
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("bp_ready_%0d", c), {28'd0, req_ready}, 32'd0);
            chk($sformatf("bp_valid_%0d", c), {31'd0, rsp_valid}, 32'd1);
            chk($sformatf("bp_id_%0d", c), {30'd0, rsp_id}, 32'd1);
            chk($sformatf("bp_sum_%0d", c), {26'd0, rsp_sum}, {26'd0, enc(5)});
            tick();
        end
        rsp_ready = 1'b1;
        #1;
        chk("bp_release_ready", {28'd0, req_ready}, 32'b1000);
        tick();
        chk("bp_release_valid", {31'd0, rsp_valid}, 32'd1);
        chk("bp_release_id", {30'd0, rsp_id}, 32'd3);
        chk("bp_release_sum", {26'd0, rsp_sum}, {26'd0, enc(1)});
        req_valid = 4'b0010;
        #1;
        chk("bp_wrap_ready", {28'd0, req_ready}, 32'b0010);
        tick();
        chk("bp_wrap_id", {30'd0, rsp_id}, 32'd1);
        req_valid = '0;
        tick();
        chk("idle_valid", {31'd0, rsp_valid}, 32'd0);
        chk("idle_busy", {31'd0, busy}, 32'd0);

`ifdef TC7_CHECK_EN
        set_op(0, 6'b000101, enc(3));
        req_valid = 4'b0001;
        tick();
        chk("err_valid", {31'd0, rsp_valid}, 32'd1);
        chk("err_flag", {31'd0, rsp_err}, 32'd1);
        set_op(0, enc(2), enc(3));
        tick();
        chk("err_clear", {31'd0, rsp_err}, 32'd0);
        chk("err_clear_sum", {26'd0, rsp_sum}, {26'd0, enc(5)});
        req_valid = '0;
        tick();
`endif

        $display("%0d/%0d checks passed", n_passed, n_total);
        $finish;
    end

endmodule

// File: doc/tc7_adder_arbiter.md
Name: tc7_adder_arbiter

Overview:
- Shares one combinational thermometer-coded modulo-7 adder (6-bit TC operands, values 0..6) between NREQ requesters.
- Round-robin arbitration with per-requester valid/ready handshakes.
- The result is captured in a one-entry output register. A response tag carries the ID of the winning requester.
- Sits between the RNS front-end issue logic and the residue-7 channel writeback.

Parameters:
- NREQ, 4, number of requesters (2..8).
- ID_W, 2, width of the response ID; must satisfy 2**ID_W >= NREQ.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- req_valid  in  NREQ  per-requester operand-valid.
- req_a  in  NREQ*6  packed TC operand A; requester i occupies [6i+5:6i]. Bit 0 is the lowest TC bit; value k = k low-order ones.
- req_b  in  NREQ*6  packed TC operand B, same packing as req_a.
- req_ready  out  NREQ  one-hot grant/accept, at most one bit high.
- rsp_valid  out  1  result register holds a valid result.
- rsp_sum  out  6  TC result, (a+b) mod 7.
- rsp_id  out  ID_W  index of the requester that produced rsp_sum.
- rsp_ready  in  1  downstream accepts the result.
- busy  out  1  high when rsp_valid is high or any req_valid is high.

Behaviour:
- Reset (rst_n low at a clk edge):
  - rsp_valid=0, rsp_sum=6'b0, rsp_id=0.
  - Round-robin pointer=0; FSM goes to EMPTY.
  - req_ready is 0 during the reset cycle.
  - A held result is discarded; no response is emitted for it.
- FSM has two states.
  - EMPTY:
    - can_accept=1.
    - Any req_valid high → grant, capture the result, go to FULL.
  - FULL:
    - can_accept=rsp_ready (pass-through refill).
    - rsp_ready high with no grant → go to EMPTY.
    - rsp_ready high with a grant → stay in FULL and load the new result.
    - rsp_ready low → hold rsp_sum and rsp_id stable.
- Grant rule:
  - Winner is the first i with req_valid[i]=1, searching from the pointer upward and wrapping modulo NREQ.
  - req_ready[winner]=can_accept. The grant is combinational from req_valid, the pointer and the state.
  - No combinational path from req_a/req_b to req_ready.
- Transfer occurs when req_valid[i] & req_ready[i]. On that edge:
  - rsp_sum <= TC sum of requester i's operands.
  - rsp_id <= i; rsp_valid <= 1.
  - pointer <= (i+1) mod NREQ.
- The pointer advances only on a transfer. With no transfer it holds.
- Latency: 1 cycle from the transfer edge to rsp_valid.
- Throughput: 1 result per cycle when rsp_ready is held high.
- Requesters must hold req_valid, req_a and req_b stable until accepted. The block does not latch operands before the grant.
- Arithmetic:
  - Sum = (value(a)+value(b)) mod 7, re-encoded as TC.
  - The bench computes the expected value using the codeword rule under Ports.
  - Result 0 encodes as 6'b000000; 6 encodes as 6'b111111.
- Simultaneous events:
  - A response drain and a new acceptance in the same cycle are legal.
  - All NREQ valid at once are served in rotating order with no starvation. Maximum wait for a requester is NREQ-1 grants.
- Non-thermometer operands produce an undefined sum unless TC7_CHECK_EN is defined.

Optional Feature:
- Macro: TC7_CHECK_EN.
- Defined:
  - Adds output port rsp_err (1 bit, reset 0), registered alongside rsp_sum.
  - rsp_err=1 if either granted operand is not a legal TC codeword (ones not contiguous from bit 0).
  - The sum is still produced and the transfer completes normally.
- Undefined: the port and checker logic are absent; behaviour is otherwise identical.

Decomposition:
- Package tc7_pkg:
  - TC7_W=6, TC7_MOD=7.
  - Function tc7_is_legal(6-bit) and function tc7_encode(int 0..6).
  - FSM state enum {EMPTY, FULL}.
- Sub-module rr_arbiter (NREQ parameter):
  - Inputs: req vector, advance strobe, can_accept.
  - Outputs: one-hot grant and binary grant index; holds the pointer.
- The modulo-7 TC adder is instantiated once, unchanged. Its operands are muxed by the grant index.

Test Plan:
- Reset mid-FULL: load a result, hold rsp_ready=0, assert rst_n=0 for 1 cycle → rsp_valid=0, rsp_sum=0, rsp_id=0, pointer=0; no stale response after release.
- Single requester 1: a=3 (000111), b=5 (011111), rsp_ready=1 → next cycle rsp_valid=1, rsp_sum=000001, rsp_id=1.
- Boundary sums, each checked against tc7_encode:
  - 0+0 → 000000.
  - 6+6 → value 5 (011111).
  - 3+4 → value 0 (000000).
  - 6+0 → value 6 (111111).
  - Exhaustive sweep of all 49 legal pairs via requester 0.
- All 4 valid continuously, rsp_ready=1 → rsp_id sequence 0,1,2,3,0,…; one result per cycle; req_ready always one-hot.
- Backpressure: rsp_ready=0 for 5 cycles while 2 requesters are valid → rsp_sum/rsp_id stable and req_ready=0. On release, the drain and the next grant happen in the same cycle.
- TC7_CHECK_EN build: a=6'b000101 (illegal), b=3 → rsp_err=1 with rsp_valid. A following legal pair gives rsp_err=0.
